// File: rtl/counter_uart_pkg.sv
// Shared definitions for the counter UART reporter: FSM states, ASCII bytes
// and the largest value that fits in the reported digit count.
package counter_uart_pkg;

  typedef enum logic [2:0] {IDLE, CONV, LOAD, START, WAIT_HI, WAIT_LO} state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int unsigned MAX_VAL(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Iterative double-dabble: one add-3/shift step per clock, WIDTH steps per start.
module bin2bcd_serial #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sh;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt - 1'b1;
    end
  end

  // High during the final shift so the parent enters LOAD as the result lands.
  assign valid = (cnt == CW'(1));

endmodule

// File: rtl/counter_uart_reporter.sv
// Snapshots the counter on req, converts it to decimal and streams the digits
// plus CR LF to the UART TX through a start/busy handshake.
module counter_uart_reporter
  import counter_uart_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] counter,
  input  logic             req,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  localparam int          IW  = $clog2(DIGITS + 2);
  localparam int unsigned SAT = MAX_VAL(DIGITS);

  state_t              state, state_d;
  logic [IW-1:0]       idx, idx_d;
  logic [7:0]          tx_data_d, cur_byte;
  logic                tx_start_d, busy_d, done_d, drop_d;
  logic                conv_start, conv_valid, last_byte;
  logic [WIDTH-1:0]    conv_bin;
  logic [4*DIGITS-1:0] bcd;

  assign conv_start = (state == IDLE) && req;
  assign conv_bin   = (32'(counter) > SAT) ? WIDTH'(SAT) : counter;
  assign last_byte  = (idx == IW'(DIGITS + 1));

  bin2bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (bcd),
    .valid (conv_valid)
  );

  // Most significant digit goes out first.
  always_comb begin
    cur_byte = ASCII_LF;
    if (idx == IW'(DIGITS)) cur_byte = ASCII_CR;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) cur_byte = ASCII_0 + {4'd0, bcd[4*(DIGITS-1-i) +: 4]};
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    drop_d     = req && (state != IDLE);
    case (state)
      IDLE: if (req) begin
        state_d = CONV;
        idx_d   = '0;
      end
      CONV:    if (conv_valid) state_d = LOAD;
      LOAD: begin
        tx_data_d = cur_byte;
        state_d   = START;
      end
      START: if (!tx_busy) begin
        tx_start_d = 1'b1;
        state_d    = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) begin
        if (last_byte) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      tx_data  <= tx_data_d;
      tx_start <= tx_start_d;
      busy     <= busy_d;
      done     <= done_d;
      drop     <= drop_d;
    end
  end

endmodule
